fmap_writer: RTL
================

Name: fmap_writer

Overview:
- Writer-side counterpart of the conv-engine row/col scan counter: accepts an output-pixel stream over a valid/ready handshake and writes it into the feature-map buffer.
- Writes in row-major order over a size x size window, at base_addr + row*pitch + col.
- Pulses done after the last pixel write; sits between the conv/MAC output stage and the feature-map SRAM write port.

Parameters:
- DATA_W, 16, pixel data width
- ADDR_W, 16, memory address width
- SIZE_W, 8, width of size/pitch/row/col

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; latches size, pitch, base_addr; honoured only in IDLE
- size  in  SIZE_W  feature-map edge length (pixels per row = rows)
- pitch  in  SIZE_W  address distance between consecutive rows (pitch >= size, not checked)
- base_addr  in  ADDR_W  address of pixel (0,0)
- in_valid  in  1  upstream pixel valid
- in_data  in  DATA_W  upstream pixel
- in_ready  out  1  block can accept a pixel
- mem_we  out  1  write strobe, one cycle per pixel
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- busy  out  1  frame in progress
- done  out  1  one-cycle completion pulse
- count  out  16  pixels accepted in the current/last frame

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; row, col, row_base, count = 0.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1 and size!=0 -> RUN.
  - Latch size, pitch, base_addr.
  - row=col=0, row_base=base_addr, count=0.
- IDLE, start=1 and size==0 -> FIN; no writes, count=0.
- RUN: in_ready=1 combinationally (in_ready=1 iff state==RUN). A beat is accepted when in_valid && in_ready.
- On an accepted beat in cycle T, the outputs are registered in T+1:
  - mem_we=1, mem_addr=row_base+col, mem_wdata=in_data; count increments.
  - mem_we=0 in any cycle following a non-accepting cycle.
- Advance after each accepted beat:
  - col==size-1 and row<size-1: col<=0, row<=row+1, row_base<=row_base+pitch.
  - col==size-1 and row==size-1: last pixel; RUN -> FIN.
  - Otherwise col<=col+1.
- FIN, one cycle: done=1, in_ready=0; the last pixel's mem_we occurs in this same cycle; then -> IDLE.
- busy=1 in RUN and FIN, 0 in IDLE.
- count holds its value in IDLE until the next start.
- start while busy is ignored; latched parameters are stable for the whole frame.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- pitch is zero-extended to ADDR_W.
- No multiplier: row_base is accumulated.
- Bubbles (in_valid=0) in RUN stall the scan; row/col hold.
- size==1: exactly one write at base_addr; done in the cycle of that write.
- Total writes per frame = size*size, at most 65025, which fits in count.
- rst mid-frame aborts immediately to IDLE with all outputs 0; no done pulse.

Decomposition:
- Shared package cnn_pkg:
  - SIZE_W, DATA_W, ADDR_W defaults
  - FSM state enum fmap_wr_state_t (IDLE/RUN/FIN)
- Sub-module fmap_addr_gen:
  - Holds row, col, row_base.
  - Inputs: load, advance.
  - Outputs: addr, last.
- Top level holds the FSM, output registers and count.

Test Plan:
- size=3, pitch=3, base=0x0100, continuous in_valid, data 1..9:
  - mem_we on 9 consecutive cycles, addr 0x0100..0x0108, wdata 1..9.
  - done=1 in the 9th write cycle; count=9; busy drops the next cycle.
- size=2, pitch=5, base=0x0010, data A,B,C,D:
  - Writes to 0x0010, 0x0011, 0x0015, 0x0016 in order.
- size=3 with in_valid toggling 1,0,1,0...:
  - Exactly 9 writes with correct sequential addresses.
  - No mem_we in a cycle following in_valid=0; done after the 9th write only.
- size=0 start:
  - done pulse 1 cycle after start; zero writes; count=0; in_ready never 1.
- rst asserted after 4 of 9 pixels, then start size=2:
  - Outputs 0 immediately and no done pulse.
  - New frame writes 4 pixels from the new base; count restarts at 0.
- start pulsed while busy with different size/base:
  - Ignored; original frame completes unchanged.
- base=0xFFFE, size=2, pitch=2:
  - Addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: default widths and the
// feature-map writer FSM state encoding.
package cnn_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int SIZE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } fmap_wr_state_t;

endpackage

// File: rtl/fmap_addr_gen.sv
// Row-major scan address generator: latches the frame geometry on load and
// steps col/row on advance, accumulating row_base instead of multiplying.
module fmap_addr_gen
    import cnn_pkg::*;
#(
    parameter int ADDR_W = cnn_pkg::ADDR_W,
    parameter int SIZE_W = cnn_pkg::SIZE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [SIZE_W-1:0] size,
    input  logic [SIZE_W-1:0] pitch,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [SIZE_W-1:0] size_q,     size_d;
    logic [SIZE_W-1:0] pitch_q,    pitch_d;
    logic [SIZE_W-1:0] row_q,      row_d;
    logic [SIZE_W-1:0] col_q,      col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [SIZE_W-1:0] size_m1;
    logic              col_end;

    assign size_m1 = size_q - SIZE_W'(1);
    assign col_end = (col_q == size_m1);
    assign last    = col_end && (row_q == size_m1);
    assign addr    = row_base_q + ADDR_W'(col_q);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        size_d     = size_q;
        pitch_d    = pitch_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        if (load) begin
            size_d     = size;
            pitch_d    = pitch;
            row_d      = '0;
            col_d      = '0;
            row_base_d = base_addr;
        end else if (advance && !last) begin
            if (col_end) begin
                col_d      = '0;
                row_d      = row_q + SIZE_W'(1);
                row_base_d = row_base_q + ADDR_W'(pitch_q);
            end else begin
                col_d = col_q + SIZE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            size_q     <= '0;
            pitch_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
        end else begin
            size_q     <= size_d;
            pitch_q    <= pitch_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/fmap_writer.sv
// Feature-map writer: accepts a pixel stream on valid/ready and writes a
// size x size window row-major into the feature-map SRAM, pulsing done at the end.
module fmap_writer
    import cnn_pkg::*;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ADDR_W = cnn_pkg::ADDR_W,
    parameter int SIZE_W = cnn_pkg::SIZE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE_W-1:0] size,
    input  logic [SIZE_W-1:0] pitch,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       count
);

    fmap_wr_state_t    state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [15:0]       count_q, count_d;
    logic              load;
    logic              accept;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid && in_ready;

    fmap_addr_gen #(
        .ADDR_W (ADDR_W),
        .SIZE_W (SIZE_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (accept),
        .size      (size),
        .pitch     (pitch),
        .base_addr (base_addr),
        .addr      (gen_addr),
        .last      (gen_last)
    );

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        count_d     = count_q;
        mem_we_d    = accept;
        mem_addr_d  = accept ? gen_addr : mem_addr_q;
        mem_wdata_d = accept ? in_data : mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (size != '0) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    count_d = count_q + 16'd1;
                    if (gen_last) state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign busy      = (state_q != IDLE);
    // The last pixel's write lands in FIN, so done coincides with it.
    assign done      = (state_q == FIN);

endmodule
